// File: rtl/am_align_if.sv
// am_align_if: lane lock/AM inputs and deskew control outputs of the alignment controller
interface am_align_if #(parameter int LANE_N = 4);
  logic [LANE_N-1:0] lock_v_i;
  logic [LANE_N-1:0] am_lite_v_i;
  logic [LANE_N-1:0] am_lite_lock_v_i;
  logic              deskew_v_i;
  logic              deskew_rst_o;
  logic              align_lock_o;
  logic [LANE_N-1:0] am_seen_o;
  logic              skew_err_o;
  logic [7:0]        lock_lost_cnt_o;
  modport master (
    output lock_v_i, am_lite_v_i, am_lite_lock_v_i, deskew_v_i,
    input  deskew_rst_o, align_lock_o, am_seen_o, skew_err_o, lock_lost_cnt_o
  );
  modport slave (
    input  lock_v_i, am_lite_v_i, am_lite_lock_v_i, deskew_v_i,
    output deskew_rst_o, align_lock_o, am_seen_o, skew_err_o, lock_lost_cnt_o
  );
endinterface

// File: rtl/am_align_ctrl.sv
// am_align_ctrl: sequences multi-lane deskew from block lock through AM capture to alignment lock
module am_align_ctrl #(
  parameter int LANE_N           = 4,
  parameter int MAX_SKEW_BLOCK_N = 27,
  parameter int AM_PERIOD        = 16384,
  parameter int AM_BAD_N         = 4
) (
  input logic       clk,
  input logic       reset,
  am_align_if.slave bus
);
  localparam int WW = $clog2(MAX_SKEW_BLOCK_N + 1);
  localparam int PW = $clog2(AM_PERIOD);
  localparam int BW = $clog2(AM_BAD_N + 1);
  typedef enum logic [1:0] {WAIT_LOCK, WAIT_AM, CHECK, ALIGNED} state_t;
  state_t            state, state_n;
  logic [LANE_N-1:0] am_seen, seen_n;
  logic [WW-1:0]     win_cnt, win_n;
  logic [PW-1:0]     per_cnt, per_n;
  logic [BW-1:0]     bad_cnt, bad_n;
  logic [7:0]        lost_cnt, lost_n;
  logic              skew_err, err_n, deskew_rst, align_lock;
  logic              all_lock, am_lock, slot, loss;
  logic [LANE_N-1:0] seen_all;
  always_comb begin
    state_n  = state;
    seen_n   = am_seen;
    win_n    = win_cnt;
    per_n    = per_cnt;
    bad_n    = bad_cnt;
    lost_n   = lost_cnt;
    err_n    = 1'b0;
    all_lock = &bus.lock_v_i;
    am_lock  = &bus.am_lite_lock_v_i;
    seen_all = am_seen | bus.am_lite_v_i;
    slot     = per_cnt == '0;
    loss     = !all_lock || !am_lock || (bus.deskew_v_i && !slot) ||
               (slot && !bus.deskew_v_i && bad_cnt == BW'(AM_BAD_N - 1));
    case (state)
      WAIT_LOCK: state_n = all_lock ? WAIT_AM : WAIT_LOCK;
      WAIT_AM: begin
        seen_n = seen_all;
        win_n  = (am_seen == '0) ? '0 : win_cnt + WW'(1);
        if (!all_lock) state_n = WAIT_LOCK;
        else if (|(bus.am_lite_v_i & am_seen)) begin
          err_n   = 1'b1;
          state_n = WAIT_LOCK;
        end else if (&seen_all) state_n = CHECK;
        else if (|am_seen && win_cnt == WW'(MAX_SKEW_BLOCK_N - 1)) begin
          err_n   = 1'b1;
          state_n = WAIT_LOCK;
        end
      end
      CHECK: begin
        if (!all_lock) state_n = WAIT_LOCK;
        else if (bus.deskew_v_i && am_lock) begin
          state_n = ALIGNED;
          per_n   = '0;
          bad_n   = '0;
        end else begin
          err_n   = 1'b1;
          state_n = WAIT_LOCK;
        end
      end
      default: begin
        per_n = (per_cnt == PW'(AM_PERIOD - 1)) ? '0 : per_cnt + PW'(1);
        bad_n = !slot ? bad_cnt : bus.deskew_v_i ? '0 : bad_cnt + BW'(1);
        if (loss) begin
          state_n = WAIT_LOCK;
          lost_n  = (lost_cnt == 8'hff) ? lost_cnt : lost_cnt + 8'd1;
        end
      end
    endcase
    if (state_n == WAIT_LOCK) seen_n = '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      am_seen    <= '0;
      win_cnt    <= '0;
      per_cnt    <= '0;
      bad_cnt    <= '0;
      lost_cnt   <= '0;
      skew_err   <= 1'b0;
      deskew_rst <= 1'b1;
      align_lock <= 1'b0;
    end else begin
      state      <= state_n;
      am_seen    <= seen_n;
      win_cnt    <= win_n;
      per_cnt    <= per_n;
      bad_cnt    <= bad_n;
      lost_cnt   <= lost_n;
      skew_err   <= err_n;
      deskew_rst <= state_n == WAIT_LOCK;
      align_lock <= state_n == ALIGNED;
    end
  end
  assign bus.deskew_rst_o    = deskew_rst;
  assign bus.align_lock_o    = align_lock;
  assign bus.am_seen_o       = am_seen;
  assign bus.skew_err_o      = skew_err;
  assign bus.lock_lost_cnt_o = lost_cnt;
endmodule
